// File: rtl/rf_wb_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_wb_driver: merges pipeline results and queued load returns (aligned to  |
// | byte lanes) into the register-file write port, with a starvation guard.    |
// | Optional macro RF_WB_SCOREBOARD_EN adds a per-register load-pending map.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rf_wb_driver #(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_valid,
  input  logic [ADDR_WIDTH-1:0]   pipe_waddr,
  input  logic [DATA_WIDTH-1:0]   pipe_wdata,
  output logic                    pipe_stall,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_WIDTH-1:0]   ld_waddr,
  input  logic [2:0]              ld_op,
  input  logic [1:0]              ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_rdata,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic [DATA_WIDTH/8-1:0] byte_wen,
  output logic [DATA_WIDTH-1:0]   wdata
`ifdef RF_WB_SCOREBOARD_EN
  ,
  input  logic                    ld_issue_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_issue_waddr,
  output logic [31:0]             busy
`endif
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  C_STARVE_MAX = ST_W'(STARVE_MAX);

  logic [ADDR_WIDTH-1:0] r_q_waddr [LQ_DEPTH];
  logic [2:0]            r_q_op    [LQ_DEPTH];
  logic [1:0]            r_q_addr  [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_rdata [LQ_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ST_W-1:0]  r_starve;

  logic w_empty, w_push, w_pop;

  assign w_empty    = (r_count == '0);
  assign ld_ready   = (r_count != C_DEPTH);
  assign pipe_stall = (r_starve == C_STARVE_MAX) && !w_empty;
  // Loads to r0 are acknowledged but never stored.
  assign w_push     = ld_valid && ld_ready && (ld_waddr != '0);
  assign w_pop      = !w_empty && (pipe_stall || !pipe_valid);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_waddr[r_wr_ptr] <= ld_waddr;
      r_q_op[r_wr_ptr]    <= ld_op;
      r_q_addr[r_wr_ptr]  <= ld_addr;
      r_q_rdata[r_wr_ptr] <= ld_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_empty || w_pop) r_starve <= '0;
      else                  r_starve <= r_starve + ST_W'(1);
    end
  end

  // Byte-lane alignment of the queue head.
  logic [DATA_WIDTH-1:0] w_m, w_sh_r, w_sh_l, w_sh_half, w_raw, w_ld_data;
  logic [1:0]            w_a;
  logic [2:0]            w_op;
  logic [15:0]           w_half;
  logic [BE_W-1:0]       w_ld_be;

  assign w_m       = r_q_rdata[r_rd_ptr];
  assign w_a       = r_q_addr[r_rd_ptr];
  assign w_op      = r_q_op[r_rd_ptr];
  assign w_sh_r    = w_m >> {w_a, 3'b000};
  assign w_sh_l    = w_m << {~w_a, 3'b000};
  assign w_sh_half = w_m >> {w_a[1], 4'b0000};
  assign w_half    = w_sh_half[15:0];

  always_comb begin
    w_raw   = '0;
    w_ld_be = {BE_W{1'b1}};
    case (w_op)
      3'd0: w_raw = {{(DATA_WIDTH-8){w_sh_r[7]}}, w_sh_r[7:0]};
      3'd1: w_raw = {{(DATA_WIDTH-8){1'b0}}, w_sh_r[7:0]};
      3'd2: w_raw = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'd3: w_raw = {{(DATA_WIDTH-16){1'b0}}, w_half};
      3'd4: w_raw = w_m;
      3'd5: begin
        w_raw   = w_sh_l;
        w_ld_be = {BE_W{1'b1}} << (~w_a);
      end
      3'd6: begin
        w_raw   = w_sh_r;
        w_ld_be = {BE_W{1'b1}} >> w_a;
      end
      default: w_ld_be = '0;
    endcase
    w_ld_data = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_ld_data[8*i +: 8] = w_raw[8*i +: 8] & {8{w_ld_be[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr    <= '0;
      byte_wen <= '0;
      wdata    <= '0;
    end else if (w_pop) begin
      waddr    <= r_q_waddr[r_rd_ptr];
      byte_wen <= w_ld_be;
      wdata    <= w_ld_data;
    end else if (pipe_valid) begin
      waddr    <= pipe_waddr;
      byte_wen <= {BE_W{1'b1}};
      wdata    <= pipe_wdata;
    end else begin
      waddr    <= '0;
      byte_wen <= '0;
      wdata    <= '0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] w_busy_set, w_busy_clr;

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (ld_issue_valid && (ld_issue_waddr != '0)) w_busy_set[ld_issue_waddr] = 1'b1;
    if (w_pop) w_busy_clr[r_q_waddr[r_rd_ptr]] = 1'b1;
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~w_busy_clr) | w_busy_set;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rf_wb_driver: randomized and directed bench with a queue-based model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rf_wb_driver;
  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic        clk, rst;
  logic        pipe_valid, pipe_stall, ld_valid, ld_ready;
  logic [4:0]  pipe_waddr, ld_waddr, waddr;
  logic [31:0] pipe_wdata, ld_rdata, wdata;
  logic [2:0]  ld_op;
  logic [1:0]  ld_addr;
  logic [3:0]  byte_wen;
`ifdef RF_WB_SCOREBOARD_EN
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_waddr;
  logic [31:0] busy;
`endif

  rf_wb_driver #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_op(ld_op),
    .ld_addr(ld_addr), .ld_rdata(ld_rdata),
    .waddr(waddr), .byte_wen(byte_wen), .wdata(wdata)
`ifdef RF_WB_SCOREBOARD_EN
    , .ld_issue_valid(ld_issue_valid), .ld_issue_waddr(ld_issue_waddr), .busy(busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [2:0]  op;
    logic [1:0]  addr;
    logic [31:0] rdata;
  } ent_t;

  ent_t lq[$];
  int   head_losses;
  int   n_tests, n_fail;
  logic obs_stall, obs_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference alignment written from the load semantics with plain arithmetic.
  function automatic void align(input ent_t e, output logic [4:0] w, output logic [3:0] b,
                                output logic [31:0] d);
    int a;
    logic [31:0] byt, half;
    a    = int'(e.addr);
    byt  = (e.rdata >> (8 * a)) & 32'hFF;
    half = (e.rdata >> (16 * (a / 2))) & 32'hFFFF;
    w    = e.waddr;
    b    = 4'b1111;
    d    = 32'h0;
    case (e.op)
      3'd0: d = (byt >= 128) ? (byt | 32'hFFFFFF00) : byt;
      3'd1: d = byt;
      3'd2: d = (half >= 32768) ? (half | 32'hFFFF0000) : half;
      3'd3: d = half;
      3'd4: d = e.rdata;
      3'd5: begin
        d = e.rdata << (8 * (3 - a));
        case (a) 0: b = 4'b1000; 1: b = 4'b1100; 2: b = 4'b1110; default: b = 4'b1111; endcase
      end
      3'd6: begin
        d = e.rdata >> (8 * a);
        case (a) 0: b = 4'b1111; 1: b = 4'b0111; 2: b = 4'b0011; default: b = 4'b0001; endcase
      end
      default: b = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) if (!b[i]) d[8*i +: 8] = 8'h00;
  endfunction

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [2:0] op,
                      input logic [1:0] ad, input logic [31:0] rd);
    logic exp_ready, exp_stall;
    logic [4:0] ew;
    logic [3:0] eb;
    logic [31:0] ed;
    ent_t e;
    pipe_valid = pv; pipe_waddr = pa; pipe_wdata = pd;
    ld_valid = lv; ld_waddr = la; ld_op = op; ld_addr = ad; ld_rdata = rd;
    #1;
    exp_ready = (lq.size() < LQ_DEPTH);
    exp_stall = (lq.size() != 0) && (head_losses == STARVE_MAX);
    obs_stall = pipe_stall;
    obs_ready = ld_ready;
    check("ld_ready", {31'b0, ld_ready}, {31'b0, exp_ready});
    check("pipe_stall", {31'b0, pipe_stall}, {31'b0, exp_stall});
    if (lq.size() != 0 && (exp_stall || !pv)) begin
      e = lq.pop_front();
      align(e, ew, eb, ed);
      head_losses = 0;
    end else if (pv) begin
      ew = pa; eb = 4'hF; ed = pd;
      if (lq.size() != 0) head_losses++;
    end else begin
      ew = '0; eb = '0; ed = '0;
    end
    if (lv && exp_ready && la != 5'd0) lq.push_back('{la, op, ad, rd});
    @(posedge clk);
    #1;
    check("waddr", {27'b0, waddr}, {27'b0, ew});
    check("byte_wen", {28'b0, byte_wen}, {28'b0, eb});
    check("wdata", wdata, ed);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pipe_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("rst_waddr", {27'b0, waddr}, 32'h0);
    check("rst_byte_wen", {28'b0, byte_wen}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
    check("rst_pipe_stall", {31'b0, pipe_stall}, 32'h0);
    lq.delete();
    head_losses = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_then_drain(input logic [2:0] op, input logic [1:0] ad, input logic [31:0] rd,
                                 input logic [3:0] exp_be, input logic [31:0] exp_d, input string tag);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, op, ad, rd);
    idle();
    check({tag, "_be"}, {28'b0, byte_wen}, {28'b0, exp_be});
    check({tag, "_data"}, wdata, exp_d);
  endtask

  initial begin
    bit accepted;
    n_tests = 0; n_fail = 0; head_losses = 0;
    rst = 1'b0;
    pipe_valid = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    ld_valid = 1'b0; ld_waddr = '0; ld_op = '0; ld_addr = '0; ld_rdata = '0;
`ifdef RF_WB_SCOREBOARD_EN
    ld_issue_valid = 1'b0; ld_issue_waddr = '0;
`endif
    @(negedge clk);
    do_reset();

    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    check("pipe_waddr", {27'b0, waddr}, 32'd5);
    check("pipe_wdata", wdata, 32'hDEADBEEF);

    load_then_drain(3'd0, 2'd2, 32'h12F45678, 4'b1111, 32'hFFFFFFF4, "lb");
    load_then_drain(3'd1, 2'd2, 32'h12F45678, 4'b1111, 32'h000000F4, "lbu");
    load_then_drain(3'd5, 2'd1, 32'hAABBCCDD, 4'b1100, 32'hCCDD0000, "lwl");
    load_then_drain(3'd6, 2'd1, 32'hAABBCCDD, 4'b0111, 32'h00AABBCC, "lwr");
    load_then_drain(3'd7, 2'd0, 32'h55555555, 4'b0000, 32'h00000000, "rsvd");

    // Starvation: load sits at the head while the pipeline never lets go.
    do_reset();
    step(1'b1, 5'd9, 32'h1111, 1'b1, 5'd4, 3'd4, 2'd0, 32'hCAFE0004);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 5'd9, 32'(k), 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
      check("stall_cycle", {31'b0, obs_stall}, (k == 5) ? 32'h1 : 32'h0);
    end
    check("starved_waddr", {27'b0, waddr}, 32'd4);
    check("starved_wdata", wdata, 32'hCAFE0004);

    // Fill the queue behind a busy pipeline, then hold a third load.
    do_reset();
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 3'd4, 2'd0, 32'h000000A1);
    step(1'b1, 5'd11, 32'hB0, 1'b1, 5'd2, 3'd4, 2'd0, 32'h000000A2);
    step(1'b1, 5'd12, 32'hC0, 1'b1, 5'd3, 3'd4, 2'd0, 32'h000000A3);
    check("full_ld_ready", {31'b0, obs_ready}, 32'h0);
    accepted = 1'b0;
    for (int k = 0; k < 12 && !accepted; k++) begin
      step(1'b1, 5'd12, 32'hC0, 1'b1, 5'd3, 3'd4, 2'd0, 32'h000000A3);
      accepted = obs_ready;
    end
    check("third_accepted", {31'b0, accepted}, 32'h1);
    for (int k = 0; k < 4; k++) idle();

    // Randomized traffic with a reset dropped into the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           3'($urandom), 2'($urandom), $urandom);
    end
    for (int k = 0; k < 4; k++) idle();

`ifdef RF_WB_SCOREBOARD_EN
    do_reset();
    check("busy_rst", busy, 32'h0);
    ld_issue_valid = 1'b1; ld_issue_waddr = 5'd7;
    idle();
    ld_issue_valid = 1'b0;
    check("busy_set", {31'b0, busy[7]}, 32'h1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'd4, 2'd0, 32'h77);
    idle();
    check("busy_clr", {31'b0, busy[7]}, 32'h0);
    ld_issue_valid = 1'b1;
    idle();
    ld_issue_valid = 1'b0;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'd4, 2'd0, 32'h78);
    ld_issue_valid = 1'b1;
    idle();
    ld_issue_valid = 1'b0;
    check("busy_set_wins", {31'b0, busy[7]}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rf_wb_driver.md
# rf_wb_driver

Writeback driver for the 32-entry register file's byte-enabled write port. It merges two writeback sources: full-word results from the in-order pipeline, and load returns from the data-memory interface. Load returns are held in a small queue and aligned to the register file's byte lanes, covering LB/LBU/LH/LHU/LW/LWL/LWR. The block arbitrates with pipeline priority plus a starvation guard, and drives registered `waddr`/`byte_wen`/`wdata` straight into the register file.

## Interface
- `LQ_DEPTH`, 2: load-return queue entries (power of two, at least 2).
- `STARVE_MAX`, 4: maximum consecutive cycles a queued load may lose to the pipeline.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `pipe_valid` input 1: pipeline full-word write request.
- `pipe_waddr` input `ADDR_WIDTH`: pipeline destination register.
- `pipe_wdata` input `DATA_WIDTH`: pipeline result.
- `pipe_stall` output 1: combinational; load wins this cycle, so the pipeline must hold its write.
- `ld_valid` input 1: load return valid.
- `ld_ready` output 1: queue can accept a load return.
- `ld_waddr` input `ADDR_WIDTH`: load destination register.
- `ld_op` input 3: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 reserved.
- `ld_addr` input 2: byte offset of the access.
- `ld_rdata` input `DATA_WIDTH`: aligned memory word.
- `waddr` output `ADDR_WIDTH`: register-file write address (registered).
- `byte_wen` output `DATA_WIDTH/8`: byte write enables (registered).
- `wdata` output `DATA_WIDTH`: write data (registered).

## Operation
- **Queue.** FIFO with `LQ_DEPTH` entries.
  - A push happens when `ld_valid && ld_ready`.
  - `ld_ready = !full`. It is registered-state only: a push when full is refused even if a pop occurs in the same cycle.
  - A load with `ld_waddr == 0` is accepted and discarded, not enqueued.
  - `ld_op == 7` is enqueued and produces `byte_wen = 0` when it is emitted.
- **Arbitration, each cycle:**
  - If `pipe_stall` = 1: pop the head and emit it. `pipe_valid` is ignored; the pipeline holds.
  - Else if `pipe_valid`: emit the pipeline write with `byte_wen = 4'b1111`.
  - Else if the queue is non-empty: pop and emit the head.
  - Else: emit `waddr = 0`, `byte_wen = 0`, `wdata = 0`.
- **Starvation.**
  - `starve_cnt` increments each cycle the queue is non-empty and no pop occurs.
  - It clears on every pop and whenever the queue is empty.
  - `pipe_stall = (starve_cnt == STARVE_MAX) && !empty`.
- **Alignment.** `a = ld_addr`, `m = ld_rdata`.
  - LB/LBU: `m[8a+7:8a]`, sign- or zero-extended; `byte_wen = 1111`.
  - LH/LHU: `m[16*a[1]+15 : 16*a[1]]`, extended; `1111`. `a[0]` is ignored because misalignment traps upstream.
  - LW: `m`; `1111`.
  - LWL: data `m << 8*(3-a)`. `byte_wen` is `1000`, `1100`, `1110`, `1111` for a = 0, 1, 2, 3.
  - LWR: data `m >> 8a`. `byte_wen` is `1111`, `0111`, `0011`, `0001` for a = 0, 1, 2, 3.
  - Bytes whose enable is clear drive 0 on `wdata`.
- **Reset.**
  - `waddr`, `byte_wen`, `wdata` = 0.
  - Queue empty, `starve_cnt` = 0.
  - Hence `ld_ready` = 1 and `pipe_stall` = 0 during reset.
  - Reset asserted mid-operation drops queued loads.

## Timing
- Pipeline write presented in cycle N appears on the outputs in N+1. The register file commits at the end of N+1, and its bypass makes the value readable during N+1.
- A load pushed in cycle N pops no earlier than N+1, because there is no queue bypass, so it reaches the outputs no earlier than N+2.
- A load that keeps losing to the pipeline is emitted after at most `STARVE_MAX + 1` cycles at the queue head.
- Pop and push in the same cycle are legal when not full; occupancy is then unchanged.
- Pointers wrap modulo `LQ_DEPTH`.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined adds three ports:
  - `ld_issue_valid` input 1
  - `ld_issue_waddr` input `ADDR_WIDTH`
  - `busy` output 32
- Scoreboard behaviour:
  - Issue sets `busy[ld_issue_waddr]`; address 0 is never set.
  - Emitting a load writeback clears its bit in the same edge that registers the outputs.
  - If set and clear hit the same register in one cycle, set wins.
  - `busy` resets to 0.
  - Issue logic must not issue a second load to a busy register.
- Undefined: these ports and all scoreboard logic are absent.

## Test plan
- Pipeline only: `pipe_valid`, `waddr` 5, `wdata` 0xDEADBEEF → next cycle `waddr` = 5, `byte_wen` = 1111, `wdata` = 0xDEADBEEF.
- LB with `a` = 2, `m` = 0x12F45678 → `wdata` = 0xFFFFFFF4, `byte_wen` = 1111. LBU gives 0x000000F4.
- LWL with `a` = 1, `m` = 0xAABBCCDD → `byte_wen` = 1100, `wdata` = 0xCCDD0000. LWR with `a` = 1 → `byte_wen` = 0111, `wdata` = 0x00AABBCC.
- One load queued with `pipe_valid` held high and `STARVE_MAX` = 4 → `pipe_stall` = 1 exactly in the 5th cycle at the head, and the load is emitted on the next cycle's outputs.
- Fill the queue with two loads while `pipe_valid` is high → `ld_ready` = 0. A third `ld_valid` is held until a pop occurs, then accepted. Output order is preserved.
- With `RF_WB_SCOREBOARD_EN`: issue to r7 → `busy[7]` = 1. Its load writeback emitted → `busy[7]` = 0. Simultaneous re-issue to r7 → `busy[7]` stays 1.
